// File: rtl/ifid_hazard_reg.sv
// IF/ID pipeline register with load-use stall, branch flush,
// fixed CALL/RET bubble run and sticky HLT.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   instr_in, PC_in     fetched instruction and its PC+1
//   stall, flush        load-use hold / EX redirect squash
//   instr_out, PC_out   register contents to decode
//   valid_out           0 when instr_out is a bubble
//   PC_hazard_out       high while bubbles follow a CALL/RET
//   fetch_hold          freeze the PC register this cycle
//   halted              HLT reached; sticky until reset
module ifid_hazard_reg #(
  parameter int          CTRL_HOLD = 3,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] PC_in,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_out,
  output logic [15:0] PC_out,
  output logic        valid_out,
  output logic        PC_hazard_out,
  output logic        fetch_hold,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;
  localparam logic [3:0] OP_HLT  = 4'b1111;
  localparam logic [3:0] HOLD_INIT = 4'(CTRL_HOLD - 1);

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [3:0]  opc;
  logic        ctl;
  logic        hlt;
  logic        do_bubble;
  logic        do_load;

  assign opc = instr_out[15:12];
  assign ctl = valid_out & ((opc == OP_CALL) | (opc == OP_RET));
  assign hlt = valid_out & (opc == OP_HLT);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    do_bubble = 1'b0;
    do_load   = 1'b0;
    case (state)
      RUN: begin
        if (flush) begin
          do_bubble = 1'b1;
        end else if (ctl & ~stall) begin
          do_bubble = 1'b1;
          state_n   = HOLD;
          cnt_n     = HOLD_INIT;
        end else if (hlt & ~stall) begin
          do_bubble = 1'b1;
          state_n   = HALT;
        end else if (~stall) begin
          do_load = 1'b1;
        end
      end
      HOLD: begin
        // stall is irrelevant here: only bubbles sit in IF/ID
        if (flush) begin
          do_bubble = 1'b1;
          state_n   = RUN;
          cnt_n     = 4'd0;
        end else if (cnt == 4'd0) begin
          do_load = 1'b1;
          state_n = RUN;
        end else begin
          do_bubble = 1'b1;
          cnt_n     = cnt - 4'd1;
        end
      end
      default: begin
        do_bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= 4'd0;
      instr_out <= NOP_INSTR;
      PC_out    <= 16'd0;
      valid_out <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (do_bubble) begin
        instr_out <= NOP_INSTR;
        PC_out    <= PC_in;
        valid_out <= 1'b0;
      end else if (do_load) begin
        instr_out <= instr_in;
        PC_out    <= PC_in;
        valid_out <= 1'b1;
      end
    end
  end

  // ctl/hlt freeze fetch while the CALL/RET/HLT is still in IF/ID
  // so the younger instruction behind it is not dropped.
  assign fetch_hold = stall
                    | ((state == RUN) & (ctl | hlt))
                    | ((state == HOLD) & (cnt != 4'd0) & ~flush)
                    | (state == HALT);

  assign PC_hazard_out = (state == HOLD);
  assign halted        = (state == HALT);

endmodule

// File: tb/tb_ifid_hazard_reg.sv
// Bench for ifid_hazard_reg: directed scenarios plus random
// stream, compared every cycle against a behavioural model.
module tb_ifid_hazard_reg;

  localparam int CH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr_in = 16'h0;
  logic [15:0] PC_in = 16'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] instr_out;
  logic [15:0] PC_out;
  logic        valid_out;
  logic        PC_hazard_out;
  logic        fetch_hold;
  logic        halted;

  int tests = 0;
  int fails = 0;

  ifid_hazard_reg #(.CTRL_HOLD(CH), .NOP_INSTR(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .instr_in(instr_in), .PC_in(PC_in),
    .stall(stall), .flush(flush),
    .instr_out(instr_out), .PC_out(PC_out),
    .valid_out(valid_out), .PC_hazard_out(PC_hazard_out),
    .fetch_hold(fetch_hold), .halted(halted)
  );

  always #5 clk = ~clk;

  // model: hold_left = bubbles still to show, counting the current one
  logic [15:0] m_instr;
  logic [15:0] m_pc;
  logic        m_valid;
  logic        m_halt;
  int          hold_left;

  function automatic logic m_ctl();
    return m_valid && (m_instr[15:12] == 4'hD || m_instr[15:12] == 4'hE);
  endfunction

  function automatic logic m_hlt();
    return m_valid && (m_instr[15:12] == 4'hF);
  endfunction

  function automatic logic m_fetch_hold();
    return stall || m_halt
        || (hold_left == 0 && (m_ctl() || m_hlt()))
        || (hold_left > 1 && !flush);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic bub;
    logic ld;
    if (rst) begin
      m_instr = 16'h0; m_pc = 16'h0; m_valid = 1'b0;
      m_halt = 1'b0; hold_left = 0;
    end else begin
      bub = 1'b0; ld = 1'b0;
      if (m_halt) bub = 1'b1;
      else if (hold_left > 0) begin
        if (flush) begin bub = 1'b1; hold_left = 0; end
        else if (hold_left == 1) begin ld = 1'b1; hold_left = 0; end
        else begin bub = 1'b1; hold_left--; end
      end
      else if (flush) bub = 1'b1;
      else if (m_ctl() && !stall) begin bub = 1'b1; hold_left = CH; end
      else if (m_hlt() && !stall) begin bub = 1'b1; m_halt = 1'b1; end
      else if (!stall) ld = 1'b1;
      if (bub) begin m_instr = 16'h0; m_pc = PC_in; m_valid = 1'b0; end
      if (ld) begin m_instr = instr_in; m_pc = PC_in; m_valid = 1'b1; end
    end
  end

  task automatic chk(input string n, input logic [15:0] a,
                     input logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_instr", instr_out, m_instr);
      chk("m_pc", PC_out, m_pc);
      chk("m_valid", 16'(valid_out), 16'(m_valid));
      chk("m_hazard", 16'(PC_hazard_out), 16'(hold_left > 0));
      chk("m_fhold", 16'(fetch_hold), 16'(m_fetch_hold()));
      chk("m_halted", 16'(halted), 16'(m_halt));
    end
  end

  task automatic drive(input logic [15:0] i, input logic [15:0] p,
                       input logic s, input logic f);
    instr_in = i; PC_in = p; stall = s; flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] op;
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 16'(valid_out), 16'h0);
    chk("rst_instr", instr_out, 16'h0000);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_hazard", 16'(PC_hazard_out), 16'h0);
    @(posedge clk); #1 rst = 1'b0;

    drive(16'h0123, 16'd1, 0, 0); tick();
    chk("add1", instr_out, 16'h0123);
    chk("add1_pc", PC_out, 16'd1);
    chk("add1_v", 16'(valid_out), 16'h1);
    drive(16'h0456, 16'd2, 0, 0); #1;
    chk("add_fh", 16'(fetch_hold), 16'h0);
    tick();
    chk("add2", instr_out, 16'h0456);
    chk("add2_pc", PC_out, 16'd2);

    drive(16'h8123, 16'd3, 0, 0); tick();
    drive(16'h9999, 16'd4, 1, 0); #1;
    chk("stall_fh", 16'(fetch_hold), 16'h1);
    tick();
    chk("stall1", instr_out, 16'h8123);
    chk("stall1_pc", PC_out, 16'd3);
    tick();
    chk("stall2", instr_out, 16'h8123);
    drive(16'h9999, 16'd4, 0, 0); tick();
    chk("unstall", instr_out, 16'h9999);

    drive(16'h0777, 16'd5, 0, 0); tick();
    drive(16'h0888, 16'd6, 0, 1); tick();
    chk("flush_i", instr_out, 16'h0000);
    chk("flush_v", 16'(valid_out), 16'h0);
    drive(16'h0888, 16'd6, 0, 0); tick();
    chk("postflush", instr_out, 16'h0888);

    drive(16'hD010, 16'd7, 0, 0); tick();
    drive(16'h1111, 16'd8, 0, 0); #1;
    chk("call_fh", 16'(fetch_hold), 16'h1);
    tick();
    chk("b1_v", 16'(valid_out), 16'h0);
    chk("b1_hz", 16'(PC_hazard_out), 16'h1);
    tick();
    chk("b2_hz", 16'(PC_hazard_out), 16'h1);
    chk("b2_fh", 16'(fetch_hold), 16'h1);
    tick();
    chk("b3_hz", 16'(PC_hazard_out), 16'h1);
    chk("b3_v", 16'(valid_out), 16'h0);
    chk("b3_fh", 16'(fetch_hold), 16'h0);
    tick();
    chk("call_ld", instr_out, 16'h1111);
    chk("call_ldv", 16'(valid_out), 16'h1);
    chk("call_hz0", 16'(PC_hazard_out), 16'h0);

    drive(16'hE000, 16'd9, 0, 0); tick();
    drive(16'h2222, 16'd10, 0, 0); tick();
    tick();
    drive(16'h3333, 16'd20, 0, 1); tick();
    chk("hf_v", 16'(valid_out), 16'h0);
    chk("hf_hz", 16'(PC_hazard_out), 16'h0);
    drive(16'h3333, 16'd20, 0, 0); tick();
    chk("hf_ld", instr_out, 16'h3333);

    drive(16'hF000, 16'd21, 0, 0); tick();
    drive(16'h4444, 16'd22, 0, 0); #1;
    chk("hlt_fh", 16'(fetch_hold), 16'h1);
    tick();
    chk("halted", 16'(halted), 16'h1);
    drive(16'h4444, 16'd22, 0, 1); tick();
    chk("halt_fl", 16'(valid_out), 16'h0);
    chk("halt_st", 16'(halted), 16'h1);
    chk("halt_fh", 16'(fetch_hold), 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_h", 16'(halted), 16'h0);
    chk("arst_v", 16'(valid_out), 16'h0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 7))
        0: op = 4'hD;
        1: op = 4'hE;
        2: op = ($urandom_range(0, 5) == 0) ? 4'hF : 4'h1;
        default: op = 4'($urandom_range(0, 12));
      endcase
      drive({op, 12'($urandom)}, 16'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      tick();
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
